sync_pkt_fifo: RTL and testbench
================================

SYNC_PKT_FIFO -- requirements
Module: sync_pkt_fifo

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 32: payload bits per word.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 7: depth = 2**P_ADDR_WIDTH words.
REQ-003 SHALL have parameter P_AFULL_THRESH, default 2**P_ADDR_WIDTH-16: almost-full threshold in words.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rstn_i, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port wr_i, input, 1: write word this cycle.
REQ-008 SHALL have port data_i, input, P_DATA_WIDTH: write word.
REQ-009 SHALL have port eop_i, input, 1: last word of packet, qualified by wr_i.
REQ-010 SHALL have port abort_i, input, 1: discard the packet in progress.
REQ-011 SHALL have port rd_valid_o, output, 1: data_o/eop_o valid.
REQ-012 SHALL have port rd_ready_i, input, 1: consumer accepts word.
REQ-013 SHALL have port data_o, output, P_DATA_WIDTH: read word.
REQ-014 SHALL have port eop_o, output, 1: read word is last of packet.
REQ-015 SHALL have port fill_level_o, output, P_ADDR_WIDTH+1: words in RAM, committed plus uncommitted.
REQ-016 SHALL have ports empty_o, full_o, almost_full_o, output, 1 each: status flags.
REQ-017 SHALL have port drop_cnt_o, output, 16: count of dropped packets.

Function
REQ-018 SHALL keep P_ADDR_WIDTH+1-bit wr_ptr (speculative), commit_ptr and rd_ptr, with wrap by natural overflow.
REQ-019 SHALL compute full_o = (wr_ptr-rd_ptr == depth), empty_o = (commit_ptr == rd_ptr), fill_level_o = wr_ptr-rd_ptr, almost_full_o = (fill_level_o >= P_AFULL_THRESH), all combinational from registered pointers.
REQ-020 SHALL store {eop_i,data_i} per word, so RAM width is P_DATA_WIDTH+1.
REQ-021 SHALL use write state ACCEPT and DROP; ACCEPT: wr_i & ~full_o writes the word and increments wr_ptr.
REQ-022 In ACCEPT, an accepted write with eop_i SHALL set commit_ptr to wr_ptr+1; the packet becomes readable only then.
REQ-023 In ACCEPT, wr_i & full_o SHALL discard the word and roll wr_ptr back to commit_ptr; with eop_i it SHALL increment drop_cnt_o and stay ACCEPT, otherwise go to DROP.
REQ-024 In DROP, all writes SHALL be ignored; wr_i & eop_i SHALL increment drop_cnt_o and return to ACCEPT.
REQ-025 abort_i SHALL take priority over wr_i in the same cycle: wr_ptr <= commit_ptr, state <= ACCEPT, the same-cycle word is discarded, drop_cnt_o unchanged.
REQ-026 drop_cnt_o SHALL saturate at 16'hFFFF.
REQ-027 SHALL issue a RAM read when ~empty_o & (~rd_valid_o | rd_ready_i); each read increments rd_ptr.
REQ-028 rd_valid_o SHALL be set the cycle after a read is issued, and cleared after a rd_valid_o & rd_ready_i handshake with no read issued.
REQ-029 data_o/eop_o SHALL come from the RAM output, held stable while rd_valid_o & ~rd_ready_i.
REQ-030 Latency: eop write accepted in cycle N -> rd_valid_o high in cycle N+2 if the output is idle.
REQ-031 With rd_ready_i held high and committed data available, throughput SHALL be one word per cycle.
REQ-032 A read in the same cycle as a write at full SHALL NOT allow that write; the freed slot is usable the next cycle.

Reset
REQ-033 rstn_i low SHALL asynchronously clear all pointers, drop_cnt_o, and rd_valid_o, and set state to ACCEPT.
REQ-034 After reset, outputs SHALL be: empty_o=1, full_o=0, almost_full_o=0, fill_level_o=0, rd_valid_o=0.
REQ-035 Reset mid-packet SHALL discard the partial packet and all stored data, with no drop counted.

Structure
REQ-036 Package sync_pkt_fifo_pkg SHALL hold the wr_state_e typedef (ACCEPT, DROP) and the constant DROP_CNT_WIDTH=16.
REQ-037 SHALL instantiate one sdp_1clk_ram (width P_DATA_WIDTH+1, addr P_ADDR_WIDTH), which holds data_rd_o when rd_i is low; no other sub-module.

Verification
REQ-038 Write a 3-word packet A0..A2 (eop on A2) with rd_ready_i=1 -> rd_valid_o rises 2 cycles after A2, A0..A2 out on consecutive cycles, eop_o only on A2.
REQ-039 Write 5 words then abort_i -> fill_level_o returns to 0, rd_valid_o stays 0, drop_cnt_o=0; the next packet reads back intact.
REQ-040 Commit 126 words, then write a 4-word packet -> words 3-4 hit full; drop_cnt_o=1, fill_level_o=126, reads return only the first 126 words.
REQ-041 Commit 10 single-word packets, toggle rd_ready_i 1/0 -> no loss or duplication, data_o stable while stalled, empty_o=1 at end.
REQ-042 Assert rstn_i low mid-packet with committed data present -> all flags at reset values immediately, drop_cnt_o=0, no stale output after release.

Source files
------------

// File: rtl/sync_pkt_fifo_pkg.sv
// Shared types and constants for the packet FIFO.
//   wr_state_e     : write-side state (ACCEPT / DROP)
//   DROP_CNT_WIDTH : width of the dropped-packet counter
//   sat_inc        : saturating increment for the drop counter
package sync_pkt_fifo_pkg;

    localparam int DROP_CNT_WIDTH = 16;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_e;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_pkt_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read.
//   clk_i      : clock
//   wr_i       : write enable; wr_addr_i / wr_data_i give location and word
//   rd_i       : read enable; data_rd_o updates the cycle after, holds otherwise
//   rd_addr_i  : read location
//   data_rd_o  : registered read data
module sdp_1clk_ram
    import sync_pkt_fifo_pkg::*;
#(
    parameter int P_WIDTH      = 33,
    parameter int P_ADDR_WIDTH = 7
) (
    input  logic                    clk_i,
    input  logic                    wr_i,
    input  logic [P_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [P_WIDTH-1:0]      wr_data_i,
    input  logic                    rd_i,
    input  logic [P_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [P_WIDTH-1:0]      data_rd_o
);

    logic [P_WIDTH-1:0] mem_q [2**P_ADDR_WIDTH];
    logic [P_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign data_rd_o = rd_data_q;

endmodule

// File: rtl/sync_pkt_fifo.sv
// Packet FIFO: words become readable only once their packet's eop is written.
// Packets that overflow, or that are aborted, are rolled back out of the RAM.
//
//   clk_i, rstn_i              : clock, async active-low reset
//   wr_i, data_i, eop_i        : write side; eop_i marks the last word
//   abort_i                    : discard the packet in progress (wins over wr_i)
//   rd_valid_o, rd_ready_i     : read handshake; data_o / eop_o the word
//   fill_level_o               : words in RAM, committed plus uncommitted
//   empty_o, full_o, almost_full_o : status flags
//   drop_cnt_o                 : saturating count of dropped packets
//
// Write state | meaning
// ACCEPT      | storing words of the current packet
// DROP        | packet overflowed; ignore words until its eop
module sync_pkt_fifo
    import sync_pkt_fifo_pkg::*;
#(
    parameter int P_DATA_WIDTH   = 32,
    parameter int P_ADDR_WIDTH   = 7,
    parameter int P_AFULL_THRESH = 2**P_ADDR_WIDTH - 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      wr_i,
    input  logic [P_DATA_WIDTH-1:0]   data_i,
    input  logic                      eop_i,
    input  logic                      abort_i,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [P_DATA_WIDTH-1:0]   data_o,
    output logic                      eop_o,
    output logic [P_ADDR_WIDTH:0]     fill_level_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      almost_full_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    localparam int                  L_RAM_W = P_DATA_WIDTH + 1;
    localparam logic [P_ADDR_WIDTH:0] L_DEPTH = {1'b1, {P_ADDR_WIDTH{1'b0}}};
    localparam logic [P_ADDR_WIDTH:0] L_AFULL = P_AFULL_THRESH[P_ADDR_WIDTH:0];

    wr_state_e                 state_q, state_d;
    logic [P_ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [P_ADDR_WIDTH:0]     commit_ptr_q, commit_ptr_d;
    logic [P_ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      rd_valid_q, rd_valid_d;

    logic                      ram_wr;
    logic                      rd_issue;
    logic [P_ADDR_WIDTH:0]     fill;
    logic [L_RAM_W-1:0]        ram_rd_data;

    // Flags come from registered pointers only, so a read in the same cycle
    // as a write at full cannot free the slot for that write.
    assign fill          = wr_ptr_q - rd_ptr_q;
    assign full_o        = (fill == L_DEPTH);
    assign empty_o       = (commit_ptr_q == rd_ptr_q);
    assign almost_full_o = (fill >= L_AFULL);
    assign fill_level_o  = fill;
    assign drop_cnt_o    = drop_cnt_q;

    // Prefetch into the output register whenever it is empty or draining.
    assign rd_issue   = ~empty_o & (~rd_valid_q | rd_ready_i);
    assign rd_ptr_d   = rd_ptr_q + {{P_ADDR_WIDTH{1'b0}}, rd_issue};
    assign rd_valid_d = rd_issue | (rd_valid_q & ~rd_ready_i);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_cnt_d   = drop_cnt_q;
        ram_wr       = 1'b0;

        if (abort_i) begin
            wr_ptr_d = commit_ptr_q;
            state_d  = ACCEPT;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (wr_i && !full_o) begin
                        ram_wr   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (eop_i) begin
                            commit_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end else if (wr_i) begin
                        // Overflow: the whole packet goes, not just this word.
                        wr_ptr_d = commit_ptr_q;
                        if (eop_i) begin
                            drop_cnt_d = sat_inc(drop_cnt_q);
                        end else begin
                            state_d = DROP;
                        end
                    end
                end
                DROP: begin
                    if (wr_i && eop_i) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = ACCEPT;
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            drop_cnt_q   <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign rd_valid_o = rd_valid_q;

    sdp_1clk_ram #(
        .P_WIDTH      (L_RAM_W),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_i      (ram_wr),
        .wr_addr_i (wr_ptr_q[P_ADDR_WIDTH-1:0]),
        .wr_data_i ({eop_i, data_i}),
        .rd_i      (rd_issue),
        .rd_addr_i (rd_ptr_q[P_ADDR_WIDTH-1:0]),
        .data_rd_o (ram_rd_data)
    );

    assign data_o = ram_rd_data[P_DATA_WIDTH-1:0];
    assign eop_o  = ram_rd_data[P_DATA_WIDTH];

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Scoreboard bench for sync_pkt_fifo (default parameters: 32-bit data,
// depth 128, almost-full at 112).
module tb_sync_pkt_fifo;

    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          wr_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          eop_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          rd_ready_i = 1'b0;
    logic          rd_valid_o;
    logic [DW-1:0] data_o;
    logic          eop_o;
    logic [AW:0]   fill_level_o;
    logic          empty_o, full_o, almost_full_o;
    logic [15:0]   drop_cnt_o;

    sync_pkt_fifo dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .wr_i          (wr_i),
        .data_i        (data_i),
        .eop_i         (eop_i),
        .abort_i       (abort_i),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .data_o        (data_o),
        .eop_o         (eop_o),
        .fill_level_o  (fill_level_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: words of the open packet, committed words in order,
    // drop-mode flag and expected drop count.
    logic [DW:0] pend_q[$];
    logic [DW:0] exp_q[$];
    bit          m_dropping = 1'b0;
    int          exp_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold while stalled.
    initial begin : monitor
        bit          stalled;
        logic [DW:0] held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_hold", {rd_valid_o, eop_o, data_o}, {1'b1, held});
                end
                if (rd_valid_o && rd_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected no word", {eop_o, data_o});
                    end else begin
                        check("rd_word", {eop_o, data_o}, exp_q.pop_front());
                    end
                end
                stalled = rd_valid_o && !rd_ready_i;
                held    = {eop_o, data_o};
            end
        end
    end

    // One write-side cycle. 'room' is the bench's own knowledge of whether a
    // free slot exists (the FIFO is only driven to full in a directed test).
    task automatic drive(input bit wr, input logic [DW-1:0] d, input bit eop,
                         input bit abt, input bit room);
        wr_i    = wr;
        data_i  = d;
        eop_i   = eop;
        abort_i = abt;
        if (abt) begin
            pend_q.delete();
            m_dropping = 1'b0;
        end else if (wr) begin
            if (m_dropping) begin
                if (eop) begin
                    m_dropping = 1'b0;
                    exp_drop++;
                end
            end else if (room) begin
                pend_q.push_back({eop, d});
                if (eop) begin
                    foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
                    pend_q.delete();
                end
            end else begin
                pend_q.delete();
                if (eop) exp_drop++;
                else     m_dropping = 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        wr_i    = 1'b0;
        eop_i   = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge clk_i);
            #1;
            i++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        idle(3);
    endtask

    initial begin : stim
        logic [DW-1:0] a [3];

        // Reset values while held in reset
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_afull", almost_full_o, 0);
        check("rst_fill", fill_level_o, 0);
        check("rst_valid", rd_valid_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        rstn_i = 1'b1;
        idle(2);

        // Three-word packet, latency and back-to-back output
        rd_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) a[i] = $urandom;
        drive(1, a[0], 0, 0, 1);
        drive(1, a[1], 0, 0, 1);
        check("uncommitted_empty", empty_o, 1);
        drive(1, a[2], 1, 0, 1);
        check("lat_n1_valid", rd_valid_o, 0);
        idle(1);
        check("lat_n2_valid", rd_valid_o, 1);
        idle(1);
        check("b2b_valid_1", rd_valid_o, 1);
        idle(1);
        check("b2b_valid_2", rd_valid_o, 1);
        idle(1);
        check("b2b_valid_end", rd_valid_o, 0);
        wait_drain(20);

        // Abort after 5 words; abort also wins over a same-cycle eop write
        for (int i = 0; i < 5; i++) drive(1, $urandom, 0, 0, 1);
        check("pre_abort_fill", fill_level_o, 5);
        drive(1, $urandom, 1, 1, 1);
        check("abort_fill", fill_level_o, 0);
        check("abort_empty", empty_o, 1);
        check("abort_drop", drop_cnt_o, exp_drop);
        idle(3);
        check("abort_valid", rd_valid_o, 0);
        for (int i = 0; i < 3; i++) drive(1, $urandom, i == 2, 0, 1);
        wait_drain(20);

        // Overflow: 127 committed (one moves to the output register), then a
        // 4-word packet whose third word hits full
        rd_ready_i = 1'b0;
        for (int i = 0; i < 127; i++) begin
            drive(1, $urandom, i == 126, 0, 1);
            if (i == 110) check("afull_below", almost_full_o, 0);
            if (i == 111) begin
                check("afull_at", almost_full_o, 1);
                check("afull_uncommitted_empty", empty_o, 1);
            end
        end
        idle(3);
        check("ovf_fill_before", fill_level_o, 126);
        check("ovf_valid", rd_valid_o, 1);
        drive(1, $urandom, 0, 0, 1);
        drive(1, $urandom, 0, 0, 1);
        check("ovf_full", full_o, 1);
        check("ovf_fill_full", fill_level_o, 128);
        drive(1, $urandom, 0, 0, 0);
        check("ovf_rollback_fill", fill_level_o, 126);
        check("ovf_not_full", full_o, 0);
        drive(1, $urandom, 1, 0, 0);
        check("ovf_drop", drop_cnt_o, exp_drop);
        check("ovf_drop_one", drop_cnt_o, 1);
        check("ovf_fill_after", fill_level_o, 126);
        rd_ready_i = 1'b1;
        wait_drain(400);
        check("ovf_drained_empty", empty_o, 1);
        check("ovf_drained_fill", fill_level_o, 0);

        // Ten single-word packets with rd_ready toggling
        for (int i = 0; i < 10; i++) begin
            rd_ready_i = i[0];
            drive(1, $urandom, 1, 0, 1);
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            rd_ready_i = ~rd_ready_i;
            idle(1);
        end
        rd_ready_i = 1'b1;
        wait_drain(20);
        check("toggle_empty", empty_o, 1);

        // Randomized traffic, outstanding words kept below depth
        for (int c = 0; c < 600; c++) begin
            bit wr, eop, abt;
            rd_ready_i = ($urandom_range(0, 3) != 0);
            abt = ($urandom_range(0, 31) == 0);
            wr  = (exp_q.size() + pend_q.size() < 100) && ($urandom_range(0, 2) != 0);
            eop = ($urandom_range(0, 3) == 0);
            drive(wr, $urandom, eop, abt, 1);
        end
        drive(0, '0, 0, 1, 1);
        rd_ready_i = 1'b1;
        wait_drain(400);
        check("rand_empty", empty_o, 1);
        check("rand_fill", fill_level_o, 0);
        check("rand_drop", drop_cnt_o, exp_drop);

        // Reset mid-packet with committed data waiting
        rd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, $urandom, i == 2, 0, 1);
        drive(1, $urandom, 0, 0, 1);
        drive(1, $urandom, 0, 0, 1);
        idle(2);
        check("prerst_valid", rd_valid_o, 1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("midrst_empty", empty_o, 1);
        check("midrst_full", full_o, 0);
        check("midrst_afull", almost_full_o, 0);
        check("midrst_fill", fill_level_o, 0);
        check("midrst_valid", rd_valid_o, 0);
        check("midrst_drop", drop_cnt_o, 0);
        exp_q.delete();
        pend_q.delete();
        m_dropping = 1'b0;
        exp_drop   = 0;
        @(posedge clk_i);
        #1;
        rstn_i     = 1'b1;
        rd_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(2);
            check("postrst_no_valid", rd_valid_o, 0);
        end
        for (int i = 0; i < 2; i++) drive(1, $urandom, i == 1, 0, 1);
        wait_drain(20);
        check("postrst_empty", empty_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
